id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary; consumes the decode-stage controller's control outputs plus register-file operands, immediate and PC.
- Registers them into the EX stage.
- Detects load-use hazards and stalls IF/ID for one cycle while inserting a bubble.
- Computes registered forwarding selects for the EX-stage operand muxes.

Parameters:
XLEN, 32, datapath width
RFIDX_WIDTH, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rd1, id_rd2  in  XLEN  register-file read data
id_imm  in  XLEN  expanded immediate
id_rs1, id_rs2, id_rd  in  RFIDX_WIDTH  register indices
id_uses_rs1, id_uses_rs2  in  1  instruction reads rs1/rs2
id_aluctrl  in  4  ALU op
id_alusrca  in  2  ALU A select
id_alusrcb  in  1  ALU B select
id_memwrite, id_lunsigned, id_memtoreg, id_regwrite  in  1  MEM/WB controls
id_lwhb, id_swhb  in  2  load/store width
mem_valid, mem_regwrite  in  1  MEM-stage state
mem_rd  in  RFIDX_WIDTH  MEM-stage destination
mem_stall  in  1  downstream freeze
flush_ex  in  1  kill instruction entering EX (branch/jump redirect)
ex_* outputs  out  widths as id_*  registered copies of every id_* field except id_valid/id_uses_*
ex_valid  out  1  EX holds a real instruction
ex_fwda, ex_fwdb  out  2  00 regfile, 01 from MEM result, 10 from WB result
stall_id  out  1  hold PC and IF/ID register this cycle
perf_lu_cnt, perf_flush_cnt  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): all ex_* outputs, ex_valid, ex_fwda, ex_fwdb and counters go to 0. Release is synchronous to clk.
- load_use (combinational): asserted when all of the following hold:
  - id_valid, ex_valid, ex_memtoreg, ex_rd != 0
  - (id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)
- stall_id = load_use | mem_stall. Combinational, same cycle.
- Per rising edge, first match wins:
  1. mem_stall=1: all EX registers hold, including ex_valid and fwd selects. flush_ex is ignored; the redirect source keeps flush_ex asserted until mem_stall drops.
  2. flush_ex=1: bubble.
  3. load_use=1: bubble.
  4. id_valid=0: bubble.
  5. Otherwise capture: every ex_* <= id_*, ex_valid <= 1.
- Bubble: ex_valid <= 0; ex_regwrite, ex_memwrite, ex_memtoreg, ex_aluctrl, ex_fwda, ex_fwdb <= 0. Remaining data fields <= 0.
- Forward select, computed at capture for rs1 (rs2 identical with fwdb):
  - 01 if ex_valid & ex_regwrite & ex_rd != 0 & ex_rd == id_rs1 (producer will be in MEM).
  - Else 10 if mem_valid & mem_regwrite & mem_rd != 0 & mem_rd == id_rs1 (producer will be in WB).
  - Else 00.
  - Forced 00 when the matching id_uses_* is 0.
- Latency: exactly 1 cycle ID->EX with no stall. A load-use hazard costs exactly one bubble. On the following cycle ex_memtoreg=0 (bubble), so load_use deasserts and the instruction captures with fwd=10 from the load.
- Index x0: never triggers load_use or forwarding.
- Simultaneous flush_ex and load_use: the flush takes priority. stall_id is still driven by load_use; the upstream redirect overrides it.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - perf_lu_cnt increments on each edge where a load_use bubble is inserted (priority 3).
  - perf_flush_cnt increments on each flush bubble (priority 2).
  - Neither increments while mem_stall=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: both outputs are constant 0 and no counter flops are built.

Test Plan:
- Reset: assert reset=0 mid-capture with id_valid=1 -> all ex_* =0 and ex_valid=0 immediately, without waiting for a clk edge.
- Normal capture: id_valid=1, id_pc=0x100, id_aluctrl=ADD, id_regwrite=1, id_rd=5 -> next cycle ex_pc=0x100, ex_rd=5, ex_valid=1, ex_fwda=00.
- Load-use: lw x5 in EX (ex_memtoreg=1, ex_rd=5), ID add x6,x5,x7 -> stall_id=1; bubble with ex_valid=0. Next edge: add captured with ex_fwda=10, ex_fwdb=00. perf_lu_cnt=1 when HAZARD_PERF_CNT_EN is defined.
- EX forward: addi x3 in EX, ID sub x4,x1,x3 -> ex_fwdb=01, stall_id=0. Same case with rd=x0 -> ex_fwdb=00.
- Flush priority: flush_ex=1 together with load_use=1 -> bubble; perf_flush_cnt=1 and perf_lu_cnt unchanged.
- mem_stall: hold mem_stall=1 for 3 cycles with flush_ex=1 -> EX registers unchanged and no counter increments. After release: bubble and perf_flush_cnt +1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble and registered forwarding selects.
// Optional hazard performance counters built when HAZARD_PERF_CNT_EN is defined.
module id_ex_stage #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [XLEN-1:0]        id_pc,
    input  logic [XLEN-1:0]        id_rd1,
    input  logic [XLEN-1:0]        id_rd2,
    input  logic [XLEN-1:0]        id_imm,
    input  logic [RFIDX_WIDTH-1:0] id_rs1,
    input  logic [RFIDX_WIDTH-1:0] id_rs2,
    input  logic [RFIDX_WIDTH-1:0] id_rd,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [3:0]             id_aluctrl,
    input  logic [1:0]             id_alusrca,
    input  logic                   id_alusrcb,
    input  logic                   id_memwrite,
    input  logic                   id_lunsigned,
    input  logic                   id_memtoreg,
    input  logic                   id_regwrite,
    input  logic [1:0]             id_lwhb,
    input  logic [1:0]             id_swhb,
    input  logic                   mem_valid,
    input  logic                   mem_regwrite,
    input  logic [RFIDX_WIDTH-1:0] mem_rd,
    input  logic                   mem_stall,
    input  logic                   flush_ex,
    output logic [XLEN-1:0]        ex_pc,
    output logic [XLEN-1:0]        ex_rd1,
    output logic [XLEN-1:0]        ex_rd2,
    output logic [XLEN-1:0]        ex_imm,
    output logic [RFIDX_WIDTH-1:0] ex_rs1,
    output logic [RFIDX_WIDTH-1:0] ex_rs2,
    output logic [RFIDX_WIDTH-1:0] ex_rd,
    output logic [3:0]             ex_aluctrl,
    output logic [1:0]             ex_alusrca,
    output logic                   ex_alusrcb,
    output logic                   ex_memwrite,
    output logic                   ex_lunsigned,
    output logic                   ex_memtoreg,
    output logic                   ex_regwrite,
    output logic [1:0]             ex_lwhb,
    output logic [1:0]             ex_swhb,
    output logic                   ex_valid,
    output logic [1:0]             ex_fwda,
    output logic [1:0]             ex_fwdb,
    output logic                   stall_id,
    output logic [31:0]            perf_lu_cnt,
    output logic [31:0]            perf_flush_cnt
);

    typedef logic [RFIDX_WIDTH-1:0] ridx_t;

    typedef struct packed {
        logic            valid;
        logic [1:0]      fwda;
        logic [1:0]      fwdb;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        ridx_t           rs1;
        ridx_t           rs2;
        ridx_t           rd;
        logic [3:0]      aluctrl;
        logic [1:0]      alusrca;
        logic            alusrcb;
        logic            memwrite;
        logic            lunsigned;
        logic            memtoreg;
        logic            regwrite;
        logic [1:0]      lwhb;
        logic [1:0]      swhb;
    } ex_t;

    ex_t  ex_q, ex_d;
    logic load_use;
    logic bubble;

    // EX producer wins over MEM producer: it is the younger write to the same register.
    function automatic logic [1:0] fwd_sel(input logic uses, input ridx_t rs,
                                           input logic ex_v, input logic ex_rw, input ridx_t ex_dst,
                                           input logic mem_v, input logic mem_rw, input ridx_t mem_dst);
        logic [1:0] sel;
        sel = 2'b00;
        if (uses && rs != '0) begin
            if (ex_v && ex_rw && ex_dst == rs)
                sel = 2'b01;
            else if (mem_v && mem_rw && mem_dst == rs)
                sel = 2'b10;
        end
        return sel;
    endfunction

    assign load_use = id_valid && ex_q.valid && ex_q.memtoreg && (ex_q.rd != '0) &&
                      ((id_uses_rs1 && id_rs1 == ex_q.rd) || (id_uses_rs2 && id_rs2 == ex_q.rd));
    assign stall_id = load_use | mem_stall;
    assign bubble   = flush_ex | load_use | ~id_valid;

    always_comb begin
        ex_d = ex_q;
        if (!mem_stall) begin
            if (bubble) begin
                ex_d = '0;
            end else begin
                ex_d.valid     = 1'b1;
                ex_d.fwda      = fwd_sel(id_uses_rs1, id_rs1, ex_q.valid, ex_q.regwrite, ex_q.rd,
                                         mem_valid, mem_regwrite, mem_rd);
                ex_d.fwdb      = fwd_sel(id_uses_rs2, id_rs2, ex_q.valid, ex_q.regwrite, ex_q.rd,
                                         mem_valid, mem_regwrite, mem_rd);
                ex_d.pc        = id_pc;
                ex_d.rd1       = id_rd1;
                ex_d.rd2       = id_rd2;
                ex_d.imm       = id_imm;
                ex_d.rs1       = id_rs1;
                ex_d.rs2       = id_rs2;
                ex_d.rd        = id_rd;
                ex_d.aluctrl   = id_aluctrl;
                ex_d.alusrca   = id_alusrca;
                ex_d.alusrcb   = id_alusrcb;
                ex_d.memwrite  = id_memwrite;
                ex_d.lunsigned = id_lunsigned;
                ex_d.memtoreg  = id_memtoreg;
                ex_d.regwrite  = id_regwrite;
                ex_d.lwhb      = id_lwhb;
                ex_d.swhb      = id_swhb;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign ex_valid     = ex_q.valid;
    assign ex_fwda      = ex_q.fwda;
    assign ex_fwdb      = ex_q.fwdb;
    assign ex_pc        = ex_q.pc;
    assign ex_rd1       = ex_q.rd1;
    assign ex_rd2       = ex_q.rd2;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_aluctrl   = ex_q.aluctrl;
    assign ex_alusrca   = ex_q.alusrca;
    assign ex_alusrcb   = ex_q.alusrcb;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_lunsigned = ex_q.lunsigned;
    assign ex_memtoreg  = ex_q.memtoreg;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_lwhb      = ex_q.lwhb;
    assign ex_swhb      = ex_q.swhb;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt, flush_cnt;

    // Flush outranks load-use, so a cycle with both only counts as a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lu_cnt    <= '0;
            flush_cnt <= '0;
        end else if (!mem_stall) begin
            if (flush_ex) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
            end else if (load_use) begin
                if (lu_cnt != '1) lu_cnt <= lu_cnt + 32'd1;
            end
        end
    end

    assign perf_lu_cnt    = lu_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_lu_cnt    = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: spec-level model checked every cycle plus literal spot checks.
module tb_id_ex_stage;

    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h3;

    logic        clk, reset;
    logic        id_valid;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [3:0]  id_aluctrl;
    logic [1:0]  id_alusrca;
    logic        id_alusrcb, id_memwrite, id_lunsigned, id_memtoreg, id_regwrite;
    logic [1:0]  id_lwhb, id_swhb;
    logic        mem_valid, mem_regwrite;
    logic [4:0]  mem_rd;
    logic        mem_stall, flush_ex;

    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_aluctrl;
    logic [1:0]  ex_alusrca;
    logic        ex_alusrcb, ex_memwrite, ex_lunsigned, ex_memtoreg, ex_regwrite;
    logic [1:0]  ex_lwhb, ex_swhb;
    logic        ex_valid;
    logic [1:0]  ex_fwda, ex_fwdb;
    logic        stall_id;
    logic [31:0] perf_lu_cnt, perf_flush_cnt;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_aluctrl(id_aluctrl), .id_alusrca(id_alusrca), .id_alusrcb(id_alusrcb),
        .id_memwrite(id_memwrite), .id_lunsigned(id_lunsigned), .id_memtoreg(id_memtoreg),
        .id_regwrite(id_regwrite), .id_lwhb(id_lwhb), .id_swhb(id_swhb),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_stall(mem_stall), .flush_ex(flush_ex),
        .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_aluctrl(ex_aluctrl), .ex_alusrca(ex_alusrca), .ex_alusrcb(ex_alusrcb),
        .ex_memwrite(ex_memwrite), .ex_lunsigned(ex_lunsigned), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_lwhb(ex_lwhb), .ex_swhb(ex_swhb),
        .ex_valid(ex_valid), .ex_fwda(ex_fwda), .ex_fwdb(ex_fwdb),
        .stall_id(stall_id), .perf_lu_cnt(perf_lu_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [1:0]  fwda, fwdb;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  aluctrl;
        logic [1:0]  alusrca;
        logic        alusrcb, memwrite, lunsigned, memtoreg, regwrite;
        logic [1:0]  lwhb, swhb;
    } ex_t;

    ex_t         m_ex;
    logic [31:0] m_lu, m_fl;
    ex_t         act;

    assign act = {ex_valid, ex_fwda, ex_fwdb, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_aluctrl, ex_alusrca, ex_alusrcb, ex_memwrite, ex_lunsigned, ex_memtoreg,
                  ex_regwrite, ex_lwhb, ex_swhb};

    // Where does register rs come from: 0 regfile, 1 the instruction now in EX, 2 the one in MEM.
    function automatic logic [1:0] source_of(input logic uses, input logic [4:0] rs, input ex_t e,
                                             input logic mv, input logic mr, input logic [4:0] md);
        if (!uses || rs == 5'd0) return 2'd0;
        if (e.valid && e.regwrite && e.rd == rs) return 2'd1;
        if (mv && mr && md == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic needs_loaded_reg(input ex_t e);
        if (!(id_valid && e.valid && e.memtoreg) || e.rd == 5'd0) return 1'b0;
        return (id_uses_rs1 && id_rs1 == e.rd) || (id_uses_rs2 && id_rs2 == e.rd);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ex = '0;
            m_lu = 0;
            m_fl = 0;
        end else if (!mem_stall) begin
            if (flush_ex) begin
                m_ex = '0;
                if (m_fl != 32'hFFFF_FFFF) m_fl = m_fl + 1;
            end else if (needs_loaded_reg(m_ex)) begin
                m_ex = '0;
                if (m_lu != 32'hFFFF_FFFF) m_lu = m_lu + 1;
            end else if (!id_valid) begin
                m_ex = '0;
            end else begin
                ex_t n;
                n.valid = 1'b1;
                n.fwda = source_of(id_uses_rs1, id_rs1, m_ex, mem_valid, mem_regwrite, mem_rd);
                n.fwdb = source_of(id_uses_rs2, id_rs2, m_ex, mem_valid, mem_regwrite, mem_rd);
                n.pc = id_pc; n.rd1 = id_rd1; n.rd2 = id_rd2; n.imm = id_imm;
                n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
                n.aluctrl = id_aluctrl; n.alusrca = id_alusrca; n.alusrcb = id_alusrcb;
                n.memwrite = id_memwrite; n.lunsigned = id_lunsigned; n.memtoreg = id_memtoreg;
                n.regwrite = id_regwrite; n.lwhb = id_lwhb; n.swhb = id_swhb;
                m_ex = n;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if (act !== m_ex) begin
                errors++;
                $display("FAIL ex_regs: got %h expected %h at %0t", act, m_ex, $time);
            end
            chk("stall_id", {31'd0, stall_id}, {31'd0, needs_loaded_reg(m_ex) | mem_stall});
`ifdef HAZARD_PERF_CNT_EN
            chk("perf_lu", perf_lu_cnt, m_lu);
            chk("perf_flush", perf_flush_cnt, m_fl);
`else
            chk("perf_lu", perf_lu_cnt, 32'd0);
            chk("perf_flush", perf_flush_cnt, 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_aluctrl = 0; id_alusrca = 0; id_alusrcb = 0; id_memwrite = 0; id_lunsigned = 0;
        id_memtoreg = 0; id_regwrite = 0; id_lwhb = 0; id_swhb = 0;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic [3:0] alu, input logic ld);
        id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_aluctrl = alu;
        id_regwrite = (rd != 0); id_memtoreg = ld; id_lwhb = ld ? 2'b10 : 2'b00;
        id_rd1 = pc ^ 32'h1111_0000; id_rd2 = pc ^ 32'h0000_2222; id_imm = pc + 32'd4;
        id_alusrca = pc[3:2]; id_alusrcb = ld; id_lunsigned = pc[2];
    endtask

    task automatic set_mem(input logic v, input logic rw, input logic [4:0] rd);
        mem_valid = v; mem_regwrite = rw; mem_rd = rd;
    endtask

    logic [31:0] exp_lu_after;

    initial begin
        reset = 1; clear_id(); set_mem(0, 0, 0); mem_stall = 0; flush_ex = 0;
        #2 reset = 0;
        #1;
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_ex_pc", ex_pc, 32'd0);
        chk("reset_perf_lu", perf_lu_cnt, 32'd0);
        @(negedge clk); #1;
        reset = 1;

        // Normal capture
        set_id(32'h100, 5'd5, 5'd1, 5'd2, 1, 1, ALU_ADD, 0);
        tick();
        chk("cap_pc", ex_pc, 32'h100);
        chk("cap_rd", {27'd0, ex_rd}, 32'd5);
        chk("cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("cap_fwda", {30'd0, ex_fwda}, 32'd0);

        // Load-use: lw x5 into EX, then add x6,x5,x7
        set_id(32'h104, 5'd5, 5'd2, 5'd0, 1, 0, ALU_ADD, 1);
        set_mem(1, 1, 5'd5);
        tick();
        set_id(32'h108, 5'd6, 5'd5, 5'd7, 1, 1, ALU_ADD, 0);
        set_mem(1, 1, 5'd5);
        #1 chk("lu_stall", {31'd0, stall_id}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("lu_cnt1", perf_lu_cnt, 32'd1);
`endif
        set_mem(1, 1, 5'd5);
        #1 chk("lu_nostall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("lu_pc", ex_pc, 32'h108);
        chk("lu_fwda", {30'd0, ex_fwda}, 32'd2);
        chk("lu_fwdb", {30'd0, ex_fwdb}, 32'd0);

        // EX forward: addi x3 then sub x4,x1,x3
        set_id(32'h10C, 5'd3, 5'd1, 5'd0, 1, 0, ALU_ADD, 0);
        set_mem(0, 0, 5'd0);
        tick();
        set_id(32'h110, 5'd4, 5'd1, 5'd3, 1, 1, ALU_SUB, 0);
        set_mem(1, 1, 5'd6);
        #1 chk("exf_nostall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("exf_fwdb", {30'd0, ex_fwdb}, 32'd1);
        chk("exf_fwda", {30'd0, ex_fwda}, 32'd0);

        // Same with x0 as producer destination (and a MEM producer of x0)
        set_id(32'h114, 5'd0, 5'd1, 5'd0, 1, 0, ALU_ADD, 0);
        id_regwrite = 1;
        tick();
        set_id(32'h118, 5'd4, 5'd1, 5'd0, 1, 1, ALU_SUB, 0);
        set_mem(1, 1, 5'd0);
        tick();
        chk("x0_fwdb", {30'd0, ex_fwdb}, 32'd0);

        // MEM match on rs2 but instruction does not read rs2 -> forced 00; rs1 from MEM -> 10
        set_id(32'h11C, 5'd9, 5'd8, 5'd8, 1, 0, ALU_ADD, 0);
        set_mem(1, 1, 5'd8);
        tick();
        chk("nouse_fwda", {30'd0, ex_fwda}, 32'd2);
        chk("nouse_fwdb", {30'd0, ex_fwdb}, 32'd0);

        // Load into x0 never stalls
        set_id(32'h120, 5'd0, 5'd1, 5'd0, 1, 0, ALU_ADD, 1);
        set_mem(0, 0, 0);
        tick();
        set_id(32'h124, 5'd6, 5'd0, 5'd0, 1, 1, ALU_ADD, 0);
        #1 chk("x0_nostall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("x0_cap", {31'd0, ex_valid}, 32'd1);

        // Flush beats load-use
        exp_lu_after = perf_lu_cnt;
        set_id(32'h128, 5'd5, 5'd2, 5'd0, 1, 0, ALU_ADD, 1);
        tick();
        set_id(32'h12C, 5'd6, 5'd5, 5'd7, 1, 1, ALU_ADD, 0);
        flush_ex = 1;
        #1 chk("fl_stall", {31'd0, stall_id}, 32'd1);
        tick();
        flush_ex = 0;
        chk("fl_bubble", {31'd0, ex_valid}, 32'd0);
        chk("fl_lu_same", perf_lu_cnt, exp_lu_after);
`ifdef HAZARD_PERF_CNT_EN
        chk("fl_cnt1", perf_flush_cnt, 32'd1);
`endif

        // mem_stall holds everything, even with flush asserted
        set_id(32'h200, 5'd10, 5'd11, 5'd12, 1, 1, ALU_SUB, 0);
        set_mem(0, 0, 0);
        tick();
        set_id(32'h204, 5'd13, 5'd10, 5'd0, 1, 0, ALU_ADD, 0);
        mem_stall = 1; flush_ex = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("ms_pc", ex_pc, 32'h200);
        chk("ms_valid", {31'd0, ex_valid}, 32'd1);
`ifdef HAZARD_PERF_CNT_EN
        chk("ms_fl_hold", perf_flush_cnt, 32'd1);
`endif
        mem_stall = 0;
        tick();
        flush_ex = 0;
        chk("ms_rel_bubble", {31'd0, ex_valid}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("ms_fl_cnt2", perf_flush_cnt, 32'd2);
`endif

        // Async reset in the middle of a cycle with a valid instruction in flight
        set_id(32'h300, 5'd7, 5'd1, 5'd2, 1, 1, ALU_ADD, 0);
        tick();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        #2 reset = 0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        chk("arst_rd", {27'd0, ex_rd}, 32'd0);
        chk("arst_flcnt", perf_flush_cnt, 32'd0);
        @(negedge clk); #1;
        reset = 1;
        tick();
        chk("post_rst_cap", ex_pc, 32'h300);
        clear_id();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
